zombie_game: RTL and testbench
==============================

ZOMBIE_GAME -- requirements
Module: zombie_game

Interface
REQ-001 Parameter N_HOLES, 3, number of zombie holes, button/LED pairs; legal range 2..8.
REQ-002 Parameter SCORE_W, 8, width of score and miss counters.
REQ-003 Parameter TICK_DIV, 1000, clk cycles per game tick; legal range >= 2.
REQ-004 Parameter GAME_TICKS, 60, game length in ticks; legal range 1..255.
REQ-005 Parameter UP_TICKS, 4, ticks a zombie stays up before escaping; legal range >= 1.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  level; rising edge requests a new game.
REQ-009 abort  in  1  level; high forces end of game.
REQ-010 btn  in  N_HOLES  punch buttons, active-high, already synchronised and debounced.
REQ-011 led  out  N_HOLES  one-hot zombie position, or all ones in FINISH.
REQ-012 score  out  SCORE_W  hit count.
REQ-013 miss  out  SCORE_W  wrong-punch plus escape count.
REQ-014 time_left  out  8  remaining ticks.
REQ-015 state  out  2  IDLE=0, PLAY=1, FINISH=2.
REQ-016 game_over  out  1  high while in FINISH.

Function
REQ-017 The FSM SHALL move IDLE->PLAY or FINISH->PLAY on a start rising edge, PLAY->FINISH when time_left reaches 0 or when abort is high, and SHALL ignore start while in PLAY.
REQ-018 On entry to PLAY, the block SHALL clear score, miss, tick counter and active zombie, and SHALL load time_left with GAME_TICKS.
REQ-019 The tick counter SHALL count 0..TICK_DIV-1 only in PLAY and SHALL assert a one-cycle tick when it wraps from TICK_DIV-1 to 0.
REQ-020 On each tick in PLAY, time_left SHALL decrement by 1; the tick that makes it 0 SHALL move the FSM to FINISH on the following edge.
REQ-021 btn and start SHALL be registered every cycle, and a press SHALL be detected as btn AND NOT the registered btn, i.e. a rising edge.
REQ-022 A 16-bit LFSR with taps 16,14,13,11 SHALL load seed 16'hACE1 on reset and advance every cycle in every state; the LFSR state SHALL never be zero.
REQ-023 On a tick with no zombie active, a zombie SHALL spawn at hole index lfsr[7:0] mod N_HOLES, with its up-counter loaded with UP_TICKS.
REQ-024 A press on the active hole SHALL increment score, clear the zombie and turn its LED off on the next edge.
REQ-025 A press on any hole while no hole press matches the active zombie, including presses with no zombie up, SHALL increment miss by exactly 1 per cycle regardless of how many bits are set.
REQ-026 If presses arrive in the same cycle on the active hole and other holes, the block SHALL count only the hit.
REQ-027 On each tick, an active zombie's up-counter SHALL decrement; when it reaches 0, the zombie SHALL escape, miss SHALL increment and the zombie SHALL clear; no respawn SHALL occur on that same tick.
REQ-028 If a hit and an escape coincide in one cycle, the block SHALL count the hit and not the escape.
REQ-029 score and miss SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-030 In PLAY, led SHALL be the one-hot active hole or 0; in FINISH, led SHALL be all ones; in IDLE, led SHALL be 0.
REQ-031 In FINISH, score, miss and time_left SHALL hold, and btn SHALL be ignored.
REQ-032 abort SHALL take priority over a coincident hit.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL set state=IDLE, led=0, score=0, miss=0, time_left=0, game_over=0, the LFSR to 16'hACE1 and the registered btn/start to 0, including mid-game.
REQ-034 After rst deasserts, a start held high from reset SHALL NOT be taken as a rising edge.

Verification
REQ-035 Bench SHALL cover: with N_HOLES=3, TICK_DIV=4, GAME_TICKS=5, pulse start -> state=1 and time_left=5; time_left reaches 0 after 20 cycles; state=2, game_over=1 and led=3'b111.
REQ-036 Bench SHALL cover: press the LED-lit hole within UP_TICKS -> score=1, led=0 next cycle, miss=0.
REQ-037 Bench SHALL cover: press an unlit hole, then press all three buttons with no zombie up -> miss=2.
REQ-038 Bench SHALL cover: with no presses and UP_TICKS=2 -> miss increments 2 ticks after each spawn, and spawn positions follow the LFSR sequence from 16'hACE1 mod 3.
REQ-039 Bench SHALL cover: with SCORE_W=2, make 5 hits -> score=3 and holds.
REQ-040 Bench SHALL cover: assert rst mid-PLAY with score=2 -> all outputs return to reset values on the next edge; a later start begins a fresh game with score=0.

Source files
------------

// File: rtl/zombie_game.sv
// Whack-a-zombie game: LFSR-placed zombies pop up each tick, punches score hits or misses.
// A zombie escapes after UP_TICKS ticks; score and miss saturate at their maximum.
module zombie_game #(
    parameter int N_HOLES    = 3,
    parameter int SCORE_W    = 8,
    parameter int TICK_DIV   = 1000,
    parameter int GAME_TICKS = 60,
    parameter int UP_TICKS   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_HOLES-1:0] btn,
    output logic [N_HOLES-1:0] led,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss,
    output logic [7:0]         time_left,
    output logic [1:0]         state,
    output logic               game_over
);
    localparam int HOLE_W = $clog2(N_HOLES);
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int UP_W   = $clog2(UP_TICKS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, FINISH = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [N_HOLES-1:0] led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d;
    logic [7:0]         time_left_q, time_left_d;
    logic               game_over_q, game_over_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [N_HOLES-1:0] btn_q, btn_d;
    logic               start_q, start_d, held_q, held_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic [HOLE_W-1:0]  hole_q, hole_d;
    logic [UP_W-1:0]    up_q, up_d;

    logic [N_HOLES-1:0] press;
    logic               start_rise, tick, hit;
    logic [1:0]         miss_inc;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                   input logic [1:0] inc);
        logic [SCORE_W:0] s;
        s = {1'b0, v} + (SCORE_W + 1)'(inc);
        if (s[SCORE_W]) return '1;
        return s[SCORE_W-1:0];
    endfunction

    // Fibonacci form, taps 16,14,13,11; a nonzero seed never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        miss_d      = miss_q;
        time_left_d = time_left_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        hole_d      = hole_q;
        up_d        = up_q;
        btn_d       = btn;
        start_d     = start;
        held_d      = held_q & start;
        lfsr_d      = lfsr_next(lfsr_q);
        miss_inc    = 2'd0;

        press      = btn & ~btn_q;
        start_rise = start & ~start_q & ~held_q;
        tick       = (state_q == PLAY) && (cnt_q == CNT_W'(TICK_DIV - 1));
        hit        = active_q && press[hole_q];

        case (state_q)
            IDLE, FINISH: begin
                if (start_rise) begin
                    state_d     = PLAY;
                    score_d     = '0;
                    miss_d      = '0;
                    cnt_d       = '0;
                    active_d    = 1'b0;
                    up_d        = '0;
                    time_left_d = 8'(GAME_TICKS);
                end
            end
            PLAY: begin
                if (abort || time_left_q == 8'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                    if (hit) begin
                        score_d  = sat_add(score_q, 2'd1);
                        active_d = 1'b0;
                    end else if (|press) begin
                        miss_inc = 2'd1;
                    end
                    if (tick) begin
                        time_left_d = time_left_q - 8'd1;
                        if (!active_q) begin
                            active_d = 1'b1;
                            hole_d   = HOLE_W'(lfsr_q[7:0] % 8'(N_HOLES));
                            up_d     = UP_W'(UP_TICKS);
                        end else if (!hit) begin
                            up_d = up_q - UP_W'(1);
                            // Escape clears the zombie; the respawn waits for the next tick.
                            if (up_q == UP_W'(1)) begin
                                active_d = 1'b0;
                                miss_inc = miss_inc + 2'd1;
                            end
                        end
                    end
                    miss_d = sat_add(miss_q, miss_inc);
                end
            end
            default: state_d = IDLE;
        endcase

        led_d = '0;
        if (state_d == FINISH) led_d = '1;
        else if (state_d == PLAY && active_d) led_d = N_HOLES'(1) << hole_d;
        game_over_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            led_q       <= '0;
            score_q     <= '0;
            miss_q      <= '0;
            time_left_q <= '0;
            game_over_q <= 1'b0;
            lfsr_q      <= 16'hACE1;
            btn_q       <= '0;
            start_q     <= 1'b0;
            held_q      <= start;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            hole_q      <= '0;
            up_q        <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            time_left_q <= time_left_d;
            game_over_q <= game_over_d;
            lfsr_q      <= lfsr_d;
            btn_q       <= btn_d;
            start_q     <= start_d;
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            hole_q      <= hole_d;
            up_q        <= up_d;
        end
    end

    assign led       = led_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign time_left = time_left_q;
    assign state     = state_q;
    assign game_over = game_over_q;
endmodule

// File: tb/tb_zombie_game.sv
// Directed bench for zombie_game: a short game (u_s) and a long 2-bit-score game (u_l)
// share one set of inputs; a reference LFSR predicts spawn holes.
module tb_zombie_game;
    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [2:0] btn;
    logic [2:0] led_s, led_l;
    logic [7:0] score_s, miss_s, time_left_s, time_left_l;
    logic [1:0] score_l, miss_l, state_s, state_l;
    logic       game_over_s, game_over_l;
    logic [15:0] m_lfsr;
    int checks = 0;
    int errors = 0;
    int ph = 0;
    int exp_h = 0;
    logic [2:0] exp_led;

    zombie_game #(.N_HOLES(3), .SCORE_W(8), .TICK_DIV(4), .GAME_TICKS(5), .UP_TICKS(2)) u_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .btn(btn), .led(led_s),
        .score(score_s), .miss(miss_s), .time_left(time_left_s), .state(state_s),
        .game_over(game_over_s));

    zombie_game #(.N_HOLES(3), .SCORE_W(2), .TICK_DIV(4), .GAME_TICKS(40), .UP_TICKS(2)) u_l (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .btn(btn), .led(led_l),
        .score(score_l), .miss(miss_l), .time_left(time_left_l), .state(state_l),
        .game_over(game_over_l));

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : ref_lfsr(m_lfsr);

    task automatic step();
        @(negedge clk);
        ph = (ph + 1) % 4;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; btn = 3'b000;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        ph = 0;
    endtask

    // Stop in the tick cycle and latch the hole a spawn there would pick.
    task automatic goto_tick();
        while (ph != 3) step();
        exp_h = int'(m_lfsr[7:0]) % 3;
        exp_led = 3'b001 << exp_h;
    endtask

    task automatic do_hit();
        goto_tick();
        step();
        btn = exp_led;
        step();
        btn = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; btn = 3'b000;
        step(); step();
        checks++; if (state_s !== 2'd0 || led_s !== 3'b000 || game_over_s !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl state=%0d led=%b go=%b exp 0/000/0", state_s, led_s, game_over_s); end
        checks++; if (score_s !== 8'd0 || miss_s !== 8'd0 || time_left_s !== 8'd0) begin
            errors++; $display("FAIL reset_cnt score=%0d miss=%0d tl=%0d exp 0", score_s, miss_s, time_left_s); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_game_timing();
        apply_reset();
        start_game();
        checks++; if (state_s !== 2'd1 || time_left_s !== 8'd5) begin
            errors++; $display("FAIL start state=%0d tl=%0d exp 1/5", state_s, time_left_s); end
        for (int k = 1; k <= 21; k++) begin
            start = (k == 7);
            step();
            if (k == 19) begin
                checks++; if (time_left_s !== 8'd1 || state_s !== 2'd1) begin
                    errors++; $display("FAIL tl_19 tl=%0d state=%0d exp 1/1", time_left_s, state_s); end
            end
            if (k == 20) begin
                checks++; if (time_left_s !== 8'd0 || state_s !== 2'd1) begin
                    errors++; $display("FAIL tl_20 tl=%0d state=%0d exp 0/1", time_left_s, state_s); end
            end
        end
        start = 1'b0;
        checks++; if (state_s !== 2'd2 || game_over_s !== 1'b1 || led_s !== 3'b111) begin
            errors++; $display("FAIL finish state=%0d go=%b led=%b exp 2/1/111", state_s, game_over_s, led_s); end
        btn = 3'b111;
        step();
        btn = 3'b000;
        step();
        checks++; if (miss_s !== 8'd1 || score_s !== 8'd0 || time_left_s !== 8'd0) begin
            errors++; $display("FAIL finish_hold miss=%0d score=%0d tl=%0d exp 1/0/0", miss_s, score_s, time_left_s); end
        start_game();
        checks++; if (state_s !== 2'd1 || time_left_s !== 8'd5 || miss_s !== 8'd0 || led_s !== 3'b000) begin
            errors++; $display("FAIL restart state=%0d tl=%0d miss=%0d led=%b exp 1/5/0/000", state_s, time_left_s, miss_s, led_s); end
    endtask

    task automatic test_hit();
        apply_reset();
        start_game();
        goto_tick();
        step();
        checks++; if (led_s !== exp_led) begin
            errors++; $display("FAIL spawn_led got=%b exp=%b", led_s, exp_led); end
        btn = exp_led;
        step();
        btn = 3'b000;
        checks++; if (score_s !== 8'd1 || led_s !== 3'b000 || miss_s !== 8'd0) begin
            errors++; $display("FAIL hit score=%0d led=%b miss=%0d exp 1/000/0", score_s, led_s, miss_s); end
    endtask

    task automatic test_miss();
        apply_reset();
        start_game();
        btn = 3'b111;
        step();
        btn = 3'b000;
        checks++; if (miss_s !== 8'd1) begin
            errors++; $display("FAIL miss_all got=%0d exp=1", miss_s); end
        goto_tick();
        step();
        btn = 3'b001 << ((exp_h + 1) % 3);
        step();
        checks++; if (miss_s !== 8'd2 || score_s !== 8'd0 || led_s !== exp_led) begin
            errors++; $display("FAIL miss_unlit miss=%0d score=%0d led=%b exp 2/0/%b", miss_s, score_s, led_s, exp_led); end
        step();
        btn = 3'b000;
        checks++; if (miss_s !== 8'd2) begin
            errors++; $display("FAIL miss_held got=%0d exp=2", miss_s); end
    endtask

    task automatic test_escape_sequence();
        logic [2:0] spawn_led;
        apply_reset();
        start_game();
        spawn_led = 3'b000;
        for (int t = 1; t <= 7; t++) begin
            goto_tick();
            if (t % 3 == 1) spawn_led = exp_led;
            step();
            if (t % 3 != 0) begin
                checks++; if (led_l !== spawn_led || miss_l !== 2'(t / 3)) begin
                    errors++; $display("FAIL seq_t%0d led=%b miss=%0d exp %b/%0d", t, led_l, miss_l, spawn_led, t / 3); end
            end else begin
                checks++; if (led_l !== 3'b000 || miss_l !== 2'(t / 3)) begin
                    errors++; $display("FAIL esc_t%0d led=%b miss=%0d exp 000/%0d", t, led_l, miss_l, t / 3); end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        start_game();
        for (int h = 1; h <= 5; h++) begin
            do_hit();
            checks++; if (score_l !== 2'((h > 3) ? 3 : h)) begin
                errors++; $display("FAIL sat_hit%0d got=%0d exp=%0d", h, score_l, (h > 3) ? 3 : h); end
        end
        repeat (6) step();
        checks++; if (score_l !== 2'd3 || miss_l !== 2'd0) begin
            errors++; $display("FAIL sat_hold score=%0d miss=%0d exp 3/0", score_l, miss_l); end
    endtask

    task automatic test_abort();
        apply_reset();
        start_game();
        goto_tick();
        step();
        btn = exp_led;
        abort = 1'b1;
        step();
        btn = 3'b000;
        abort = 1'b0;
        checks++; if (state_s !== 2'd2 || score_s !== 8'd0 || game_over_s !== 1'b1 || led_s !== 3'b111) begin
            errors++; $display("FAIL abort state=%0d score=%0d go=%b led=%b exp 2/0/1/111", state_s, score_s, game_over_s, led_s); end
    endtask

    task automatic test_reset_mid_game();
        apply_reset();
        start_game();
        do_hit();
        do_hit();
        checks++; if (score_s !== 8'd2) begin
            errors++; $display("FAIL pre_rst score=%0d exp=2", score_s); end
        rst = 1'b1;
        start = 1'b1;
        step();
        checks++; if (state_s !== 2'd0 || led_s !== 3'b000 || score_s !== 8'd0 || miss_s !== 8'd0 ||
                      time_left_s !== 8'd0 || game_over_s !== 1'b0) begin
            errors++; $display("FAIL mid_rst state=%0d led=%b score=%0d miss=%0d tl=%0d go=%b exp all 0",
                               state_s, led_s, score_s, miss_s, time_left_s, game_over_s); end
        rst = 1'b0;
        repeat (3) step();
        checks++; if (state_s !== 2'd0) begin
            errors++; $display("FAIL held_start state=%0d exp=0", state_s); end
        start = 1'b0;
        step();
        start_game();
        checks++; if (state_s !== 2'd1 || score_s !== 8'd0 || time_left_s !== 8'd5) begin
            errors++; $display("FAIL fresh state=%0d score=%0d tl=%0d exp 1/0/5", state_s, score_s, time_left_s); end
        goto_tick();
        step();
        checks++; if (led_s !== exp_led) begin
            errors++; $display("FAIL fresh_spawn led=%b exp=%b", led_s, exp_led); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; btn = 3'b000;
        @(negedge clk);
        test_reset();
        test_game_timing();
        test_hit();
        test_miss();
        test_escape_sequence();
        test_saturation();
        test_abort();
        test_reset_mid_game();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
